// File: rtl/osc_meas_pkg.sv
// Shared types and default constants for the oscillator measurement scheduler.
package osc_meas_pkg;

  localparam int CNT_W_DEF      = 16;
  localparam int WINDOW_CYC_DEF = 1024;
  localparam int SETTLE_CYC_DEF = 16;
  localparam int SYNC_CYC_DEF   = 4;

  localparam logic SRC_INV  = 1'b0;
  localparam logic SRC_NAND = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_GATE,
    ST_HOLD,
    ST_CAPTURE,
    ST_REPORT
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/osc_meas_timer.sv
// Loadable down-counter; done_o is high while the count sits at zero.
// Loading N yields N+1 cycles before done_o, so phases load their length minus one.
module osc_meas_timer #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/osc_meas_sched.sv
// Ring-oscillator measurement sequencer: settle, gate, hold, capture, then valid/ready report (holds until accepted).
// OSC_MEAS_AVG_EN: each result averages four windows on the same source.
module osc_meas_sched
  import osc_meas_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int WINDOW_CYC = WINDOW_CYC_DEF,
  parameter int SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int SYNC_CYC   = SYNC_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             alt_mode,
  input  logic             osc_sel,
  input  logic [CNT_W-1:0] thr_set,
  input  logic [CNT_W-1:0] thr_clr,
  input  logic [CNT_W-1:0] cnt_val,
  output logic             en_inv_osc,
  output logic             en_nand_osc,
  output logic             cnt_clr,
  output logic             cnt_gate,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_data,
  output logic             res_src,
  output logic             temp_warn
);

  localparam int TMR_W = $clog2(max3(WINDOW_CYC, SETTLE_CYC, SYNC_CYC) + 1);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] WINDOW_LD = TMR_W'(WINDOW_CYC - 1);
  localparam logic [TMR_W-1:0] SYNC_LD   = TMR_W'(SYNC_CYC - 1);

  state_t           state_q, state_d;
  logic             src_q, src_d;
  logic             alt_q, alt_d;
  logic [CNT_W-1:0] res_data_q, res_data_d;
  logic             res_src_q, res_src_d;
  logic             warn_q, warn_d;
  logic             tmr_load, tmr_done;
  logic [TMR_W-1:0] tmr_val;
  logic             capture, last_win, osc_en;
  logic [CNT_W-1:0] result;

  osc_meas_timer #(.W(TMR_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

`ifdef OSC_MEAS_AVG_EN
  logic [CNT_W+1:0] acc_q, acc_d, acc_sum;
  logic [1:0]       win_q, win_d;

  assign acc_sum  = acc_q + {2'b00, cnt_val};
  assign result   = acc_sum[CNT_W+1:2];
  assign last_win = (win_q == 2'd3);

  always_comb begin
    acc_d = acc_q;
    win_d = win_q;
    if (capture) begin
      if (last_win) begin
        acc_d = '0;
        win_d = '0;
      end else begin
        acc_d = acc_sum;
        win_d = win_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      win_q <= '0;
    end else begin
      acc_q <= acc_d;
      win_q <= win_d;
    end
  end
`else
  assign result   = cnt_val;
  assign last_win = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    alt_d     = alt_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    capture   = 1'b0;
    osc_en    = 1'b0;
    cnt_clr   = 1'b0;
    cnt_gate  = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (run) begin
          state_d  = ST_SETTLE;
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LD;
          src_d    = alt_mode ? alt_q : osc_sel;
        end
      end
      ST_SETTLE: begin
        osc_en  = 1'b1;
        cnt_clr = 1'b1;
        if (tmr_done) begin
          state_d  = ST_GATE;
          tmr_load = 1'b1;
          tmr_val  = WINDOW_LD;
        end
      end
      ST_GATE: begin
        osc_en   = 1'b1;
        cnt_gate = 1'b1;
        if (tmr_done) begin
          state_d  = ST_HOLD;
          tmr_load = 1'b1;
          tmr_val  = SYNC_LD;
        end
      end
      ST_HOLD: begin
        if (tmr_done) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        capture = 1'b1;
        // Intermediate averaging windows loop back without re-picking the source.
        if (last_win) begin
          state_d = ST_REPORT;
        end else begin
          state_d  = ST_SETTLE;
          tmr_load = 1'b1;
          tmr_val  = SETTLE_LD;
        end
      end
      ST_REPORT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          if (alt_mode) alt_d = ~alt_q;
          if (run) begin
            state_d  = ST_SETTLE;
            tmr_load = 1'b1;
            tmr_val  = SETTLE_LD;
            src_d    = alt_mode ? alt_d : osc_sel;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Set rule is checked first so an inverted threshold pair still resolves deterministically.
  always_comb begin
    res_data_d = res_data_q;
    res_src_d  = res_src_q;
    warn_d     = warn_q;
    if (capture && last_win) begin
      res_data_d = result;
      res_src_d  = src_q;
      if (result < thr_set) begin
        warn_d = 1'b1;
      end else if (result > thr_clr) begin
        warn_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      src_q      <= SRC_INV;
      alt_q      <= SRC_INV;
      res_data_q <= '0;
      res_src_q  <= SRC_INV;
      warn_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      alt_q      <= alt_d;
      res_data_q <= res_data_d;
      res_src_q  <= res_src_d;
      warn_q     <= warn_d;
    end
  end

  assign en_inv_osc  = osc_en && (src_q == SRC_INV);
  assign en_nand_osc = osc_en && (src_q == SRC_NAND);
  assign res_data    = res_data_q;
  assign res_src     = res_src_q;
  assign temp_warn   = warn_q;

endmodule

// File: tb/tb_osc_meas_sched.sv
// Directed and randomized bench for osc_meas_sched against a per-measurement reference model.
module tb_osc_meas_sched;

  localparam int CNT_W  = 16;
  localparam int WINDOW = 1024;
  localparam int SETTLE = 16;
`ifdef OSC_MEAS_AVG_EN
  localparam int NWIN = 4;
`else
  localparam int NWIN = 1;
`endif

  logic             clk = 1'b0;
  logic             rst_n, run, alt_mode, osc_sel, res_ready;
  logic [CNT_W-1:0] thr_set, thr_clr, cnt_val;
  logic             en_inv_osc, en_nand_osc, cnt_clr, cnt_gate;
  logic             res_valid, res_src, temp_warn;
  logic [CNT_W-1:0] res_data;

  int   checks = 0;
  int   errors = 0;
  logic model_warn, model_alt, exp_next_src;

  logic [CNT_W-1:0] hv[4] = '{16'd700, 16'd350, 16'd500, 16'd650};
  logic             hw[4] = '{1'b0, 1'b1, 1'b1, 1'b0};

  always #5 clk = ~clk;

  osc_meas_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .alt_mode    (alt_mode),
    .osc_sel     (osc_sel),
    .thr_set     (thr_set),
    .thr_clr     (thr_clr),
    .cnt_val     (cnt_val),
    .en_inv_osc  (en_inv_osc),
    .en_nand_osc (en_nand_osc),
    .cnt_clr     (cnt_clr),
    .cnt_gate    (cnt_gate),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_src     (res_src),
    .temp_warn   (temp_warn)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    run   = 1'b0;
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_outs", {en_inv_osc, en_nand_osc, cnt_clr, cnt_gate, res_valid, res_src, temp_warn}, 7'b0010000);
    chk("rst_data", res_data, 0);
    rst_n = 1'b1;
    model_warn = 1'b0;
    model_alt  = 1'b0;
  endtask

  task automatic start_run();
    run = 1'b1;
    exp_next_src = alt_mode ? model_alt : osc_sel;
  endtask

  // One full result: count enable/gate cycles, check the report, optional stall, then the handshake.
  task automatic do_meas(input logic [CNT_W-1:0] v, input int stall, input bit drop_run);
    int n_inv = 0, n_nand = 0, n_gate = 0, n_both = 0, starts = 0, cyc = 0, bad = 0, sum = 0;
    logic gate_prev = 1'b0;
    logic src;
    logic [CNT_W-1:0] exp_res, held;
    src = exp_next_src;
    for (int k = 0; k < NWIN; k++) sum += int'(v) + k;
    exp_res = CNT_W'(sum / NWIN);
    forever begin
      if (en_inv_osc) n_inv++;
      if (en_nand_osc) n_nand++;
      if (cnt_gate) n_gate++;
      if (en_inv_osc && en_nand_osc) n_both++;
      if (cnt_gate && !gate_prev) begin
        cnt_val = v + CNT_W'(starts);
        starts++;
        if (drop_run) run = 1'b0;
      end
      gate_prev = cnt_gate;
      if (res_valid || cyc >= NWIN * 1200 + 50) break;
      @(negedge clk);
      cyc++;
    end
    if (exp_res < thr_set) model_warn = 1'b1;
    else if (exp_res > thr_clr) model_warn = 1'b0;
    chk("result_valid", res_valid, 1);
    chk("res_data", res_data, exp_res);
    chk("res_src", res_src, src);
    chk("temp_warn", temp_warn, model_warn);
    chk("en_sel_cycles", src ? n_nand : n_inv, NWIN * (SETTLE + WINDOW));
    chk("en_other_cycles", src ? n_inv : n_nand, 0);
    chk("gate_cycles", n_gate, NWIN * WINDOW);
    chk("both_en", n_both, 0);
    held = res_data;
    if (stall > 0) begin
      res_ready = 1'b0;
      repeat (stall) begin
        @(negedge clk);
        if (res_valid !== 1'b1 || res_data !== held || res_src !== src ||
            en_inv_osc !== 1'b0 || en_nand_osc !== 1'b0 || cnt_gate !== 1'b0) bad++;
      end
      chk("stall_stable", bad, 0);
      res_ready = 1'b1;
    end
    if (alt_mode) model_alt = ~model_alt;
    exp_next_src = alt_mode ? model_alt : osc_sel;
    @(negedge clk);
    chk("valid_drop", res_valid, 0);
    if (run)
      chk("settle_after_hs", {en_inv_osc, en_nand_osc, cnt_clr, cnt_gate}, {~exp_next_src, exp_next_src, 1'b1, 1'b0});
    else
      chk("idle_after_hs", {en_inv_osc, en_nand_osc, cnt_clr, cnt_gate}, 4'b0010);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; run = 1'b0; alt_mode = 1'b0; osc_sel = 1'b0; res_ready = 1'b1;
    thr_set = '0; thr_clr = '1; cnt_val = '0;
    model_warn = 1'b0; model_alt = 1'b0; exp_next_src = 1'b0;

    apply_reset();
    repeat (5) @(negedge clk);
    chk("idle_hold", {en_inv_osc, en_nand_osc, cnt_clr, cnt_gate, res_valid}, 5'b00100);

    // Basic inverter measurement, then the hysteresis sequence.
    start_run();
    do_meas(16'd500, 0, 1'b0);
    thr_set = 16'd400;
    thr_clr = 16'd600;
    for (int i = 0; i < 4; i++) begin
      do_meas(hv[i], 0, 1'b0);
      chk("warn_seq", temp_warn, hw[i]);
    end

    // Source switch via osc_sel, long stall, then run dropped mid-measurement.
    osc_sel = 1'b1;
    do_meas(16'd321, 0, 1'b0);
    do_meas(16'd888, 200, 1'b0);
    do_meas(16'd222, 0, 1'b1);
    repeat (5) @(negedge clk);
    chk("idle_after_stop", {en_inv_osc, en_nand_osc, cnt_clr, cnt_gate, res_valid}, 5'b00100);

    // Alternating sources from reset.
    apply_reset();
    alt_mode = 1'b1;
    osc_sel  = 1'b0;
    start_run();
    for (int i = 0; i < 4; i++) begin
      do_meas(CNT_W'($urandom_range(0, 2 ** CNT_W - 5)), 0, 1'b0);
      chk("alt_seq", res_src, i % 2);
    end

    // Force temp_warn high, then reset in the middle of the next gate window.
    thr_set = 16'd400;
    thr_clr = 16'd600;
    do_meas(16'd100, 0, 1'b0);
    chk("warn_before_rst", temp_warn, 1);
    cyc = 0;
    while (!cnt_gate && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("gate_reached", cnt_gate, 1);
    repeat (37) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midgate_rst_outs", {en_inv_osc, en_nand_osc, cnt_clr, cnt_gate, res_valid, temp_warn}, 6'b001000);
    chk("midgate_rst_data", res_data, 0);
    rst_n = 1'b1;
    run = 1'b0;
    model_warn = 1'b0;
    model_alt  = 1'b0;
    @(negedge clk);

    // Randomized thresholds (including inverted pairs), values, modes and stalls.
    for (int i = 0; i < 4; i++) begin
      thr_set  = CNT_W'($urandom_range(0, 1000));
      thr_clr  = CNT_W'($urandom_range(0, 1000));
      alt_mode = 1'($urandom_range(0, 1));
      osc_sel  = 1'($urandom_range(0, 1));
      if (i == 0) start_run();
      do_meas(CNT_W'($urandom_range(0, 1200)), $urandom_range(0, 20), i == 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
